la_spi_target: RTL and testbench
================================

// Module: la_spi_target
// PURPOSE
// - SPI target (peripheral) endpoint: the receiving end of a host-driven SPI link (mode 0, MSB first).
// - Oversamples pad-side sck/csn/sd in the core clock domain and decodes frames as [R/W bit][address][data].
// - Frames become single-cycle register write pulses or read requests on a simple register port.
// - Sits between the SPI pads and a local register file; drives sd_out/sd_oe back to the pad.
// PARAMETERS
// - AW  7  register address width; command word is AW+1 bits, with bit AW = 1 for read.
// - DW  8  register data width; bits per data word.
// PORTS
// - clk          in   1   core clock; must be at least 8x the sck frequency
// - reset        in   1   asynchronous, active-high reset
// - spi_sck_in   in   1   serial clock from host (async to clk)
// - spi_csn_in   in   1   chip select, active low (async)
// - spi_sd_in    in   1   host-to-target serial data (async)
// - spi_sd_out   out  1   target-to-host serial data
// - spi_sd_oe    out  1   output enable for spi_sd_out
// - wr_valid     out  1   one-cycle write strobe
// - wr_addr      out  AW  write address, valid with wr_valid
// - wr_data      out  DW  write data, valid with wr_valid
// - rd_req       out  1   one-cycle read request
// - rd_addr      out  AW  read address, held from rd_req until the next rd_req
// - rd_data      in   DW  read data, sampled exactly 1 clk after rd_req
// - busy         out  1   frame in progress (csn low, synchronised)
// - frame_err    out  1   one-cycle pulse: csn rose mid-word
// BEHAVIOUR
// - Synchronisation and edges
//   - sck, csn and sd each pass through a 2-flop synchroniser.
//   - rise and fall are single-clk pulses derived from the synchronised sck and its previous value.
//   - Edges are ignored while synchronised csn is high.
// - Reset values: all outputs and internal state 0, except spi_sd_out=0 and spi_sd_oe=0. State = IDLE.
// - FSM states: IDLE, CMD, WDATA, RDATA, HOLD.
//   - IDLE -> CMD on a csn falling edge; bit counter cleared.
//   - CMD: shift sd in on each sck rise; after AW+1 bits, branch on the R/W bit.
//     - W=0 -> WDATA.
//     - R=1 -> RDATA, with rd_req pulsed in the same clk as the final rise and rd_addr latched.
//   - WDATA: shift DW bits on sck rises; on the final bit, pulse wr_valid the next clk with wr_addr/wr_data, then -> HOLD.
//   - RDATA:
//     - Load shifter with rd_data at rd_req+1; spi_sd_oe=1.
//     - spi_sd_out = shifter MSB, updated only on sck fall; the first fall after the command presents data bit DW-1.
//     - After DW falls -> HOLD.
//   - HOLD: ignore sck; spi_sd_oe=0.
// - csn rising edge (any state) -> IDLE, spi_sd_oe=0 within 3 clk. frame_err pulses if state was CMD/WDATA/RDATA with a partial word; no wr_valid is issued.
// - Back-to-back frames: csn high for >=2 clk then low starts a fresh frame; no state leaks between frames.
// - Extra sck edges while in HOLD produce no strobes and spi_sd_out stays 0.
// - Reset mid-frame: immediate IDLE; subsequent bits are ignored until the next csn falling edge.
// - Latency: wr_valid <= 4 clk after the final sck rise (sync 2 + shift 1 + strobe 1).
// CONFIGURATION
// - LA_SPI_TARGET_BURST_EN defined:
//   - After each data word, stay in WDATA/RDATA instead of HOLD; address += 1, wrapping at 2^AW.
//   - Reads issue the next rd_req on the final sck rise of each word.
// - Not defined: exactly one data word per frame, then HOLD until csn rises.
// TESTING
// - Write addr 0x05 data 0xA5 (bits 0_0000101_10100101) -> one wr_valid, wr_addr=0x05, wr_data=0xA5, frame_err=0.
// - Read addr 0x12 with rd_data=0x3C -> rd_req once, rd_addr=0x12, MISO 0,0,1,1,1,1,0,0 on 8 falls; sd_oe high only in data phase.
// - csn raised after 5 command bits -> frame_err one pulse, no wr_valid/rd_req, state IDLE.
// - Assert reset at data bit 3 of a write -> no wr_valid; next full frame writing 0x7F=0x01 succeeds.
// - Two consecutive frames (write 0x01=0xFF, read 0x01) with csn high for 2 clk -> both serviced correctly.
// - BURST_EN: write addr 0x7F with data 0x11,0x22 -> wr_valid at (0x7F,0x11) then (0x00,0x22); without macro only the first.

Source files
------------

// File: rtl/la_spi_target.sv
// SPI mode-0 target: oversampled pads, [R/W][addr][data] frames to a register port.
// Optional burst mode (auto-incrementing address) enabled by LA_SPI_TARGET_BURST_EN.
module la_spi_target #(
  parameter int AW = 7,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          spi_sck_in,
  input  logic          spi_csn_in,
  input  logic          spi_sd_in,
  output logic          spi_sd_out,
  output logic          spi_sd_oe,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          frame_err
);
  localparam int MAXW = (AW + 1 > DW) ? AW + 1 : DW;
  localparam int CW   = $clog2(MAXW + 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(AW);
  localparam logic [CW-1:0] WR_LAST  = CW'(DW - 1);
  localparam logic [CW-1:0] RD_FULL  = CW'(DW);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, HOLD} state_t;

  // Pad order: [2]=sck, [1]=csn, [0]=sd. Everything resets to 0 so a
  // reset while csn is low never looks like a fresh csn falling edge.
  logic [2:0] pad_in;
  logic [2:0] sync1_reg, sync2_reg;
  logic       sck_prev_reg, csn_prev_reg;

  assign pad_in = {spi_sck_in, spi_csn_in, spi_sd_in};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync1_reg[gi] <= 1'b0;
          sync2_reg[gi] <= 1'b0;
        end else begin
          sync1_reg[gi] <= pad_in[gi];
          sync2_reg[gi] <= sync1_reg[gi];
        end
      end
    end
  endgenerate

  logic sck_s, csn_s, sd_s;
  logic sck_rise, sck_fall, csn_fall, csn_rise;

  assign sck_s    = sync2_reg[2];
  assign csn_s    = sync2_reg[1];
  assign sd_s     = sync2_reg[0];
  assign sck_rise = sck_s & ~sck_prev_reg & ~csn_s;
  assign sck_fall = ~sck_s & sck_prev_reg & ~csn_s;
  assign csn_fall = csn_prev_reg & ~csn_s;
  assign csn_rise = ~csn_prev_reg & csn_s;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [AW-1:0] cmd_reg, cmd_next;
  logic [DW-1:0] data_reg, data_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic          rd_mid_reg, rd_mid_next;
  logic          wr_valid_reg, wr_valid_next;
  logic [AW-1:0] wr_addr_reg, wr_addr_next;
  logic [DW-1:0] wr_data_reg, wr_data_next;
  logic          rd_req_reg, rd_req_next;
  logic [AW-1:0] rd_addr_reg, rd_addr_next;
  logic          sd_out_reg, sd_out_next;
  logic          sd_oe_reg, sd_oe_next;
  logic          busy_reg, busy_next;
  logic          err_reg, err_next;

  logic [AW:0]   cmd_full;
  logic [DW-1:0] wr_word;

  assign cmd_full = {cmd_reg, sd_s};
  assign wr_word  = {data_reg[DW-2:0], sd_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_prev_reg <= 1'b0;
      csn_prev_reg <= 1'b0;
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      cmd_reg      <= '0;
      data_reg     <= '0;
      addr_reg     <= '0;
      rd_mid_reg   <= 1'b0;
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      rd_req_reg   <= 1'b0;
      rd_addr_reg  <= '0;
      sd_out_reg   <= 1'b0;
      sd_oe_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      sck_prev_reg <= sck_s;
      csn_prev_reg <= csn_s;
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      cmd_reg      <= cmd_next;
      data_reg     <= data_next;
      addr_reg     <= addr_next;
      rd_mid_reg   <= rd_mid_next;
      wr_valid_reg <= wr_valid_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
      rd_req_reg   <= rd_req_next;
      rd_addr_reg  <= rd_addr_next;
      sd_out_reg   <= sd_out_next;
      sd_oe_reg    <= sd_oe_next;
      busy_reg     <= busy_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    cmd_next      = cmd_reg;
    data_next     = data_reg;
    addr_next     = addr_reg;
    rd_mid_next   = rd_mid_reg;
    wr_valid_next = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    rd_req_next   = 1'b0;
    rd_addr_next  = rd_addr_reg;
    sd_out_next   = sd_out_reg;
    sd_oe_next    = sd_oe_reg;
    err_next      = 1'b0;

    // Read data arrives one clock after the request.
    if (rd_req_reg) begin
      data_next  = rd_data;
      sd_oe_next = 1'b1;
    end

    unique case (state_reg)
      IDLE: begin
        if (csn_fall) begin
          state_next = CMD;
          cnt_next   = '0;
        end
      end
      CMD: begin
        if (sck_rise) begin
          cmd_next = cmd_full[AW-1:0];
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CMD_LAST) begin
            cnt_next  = '0;
            addr_next = cmd_full[AW-1:0];
            if (cmd_full[AW]) begin
              state_next   = RDATA;
              rd_req_next  = 1'b1;
              rd_addr_next = cmd_full[AW-1:0];
              rd_mid_next  = 1'b0;
            end else begin
              state_next = WDATA;
            end
          end
        end
      end
      WDATA: begin
        if (sck_rise) begin
          data_next = wr_word;
          cnt_next  = cnt_reg + 1'b1;
          if (cnt_reg == WR_LAST) begin
            wr_valid_next = 1'b1;
            wr_addr_next  = addr_reg;
            wr_data_next  = wr_word;
            cnt_next      = '0;
`ifdef LA_SPI_TARGET_BURST_EN
            addr_next     = addr_reg + 1'b1;
`else
            state_next    = HOLD;
`endif
          end
        end
      end
      RDATA: begin
        // Falls shift the next bit out; the rise after the last fall closes the word.
        if (sck_fall && cnt_reg != RD_FULL) begin
          sd_out_next = data_reg[DW-1];
          data_next   = {data_reg[DW-2:0], 1'b0};
          cnt_next    = cnt_reg + 1'b1;
        end else if (sck_rise) begin
          if (cnt_reg == RD_FULL) begin
            cnt_next    = '0;
            rd_mid_next = 1'b0;
`ifdef LA_SPI_TARGET_BURST_EN
            addr_next    = addr_reg + 1'b1;
            rd_req_next  = 1'b1;
            rd_addr_next = addr_reg + 1'b1;
`else
            state_next   = HOLD;
`endif
          end else begin
            rd_mid_next = 1'b1;
          end
        end
      end
      HOLD: ;
      default: state_next = IDLE;
    endcase

    if (csn_rise) begin
      err_next      = ((state_reg == CMD || state_reg == WDATA) && cnt_reg != '0) ||
                      (state_reg == RDATA && rd_mid_reg);
      state_next    = IDLE;
      cnt_next      = '0;
      rd_mid_next   = 1'b0;
      wr_valid_next = 1'b0;
      rd_req_next   = 1'b0;
    end

    if (state_next != RDATA) begin
      sd_out_next = 1'b0;
      sd_oe_next  = 1'b0;
    end
    busy_next = (state_next != IDLE);
  end

  assign spi_sd_out = sd_out_reg;
  assign spi_sd_oe  = sd_oe_reg;
  assign wr_valid   = wr_valid_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign rd_req     = rd_req_reg;
  assign rd_addr    = rd_addr_reg;
  assign busy       = busy_reg;
  assign frame_err  = err_reg;
endmodule

// File: tb/tb_la_spi_target.sv
// Self-checking bench for la_spi_target: host-side SPI driver, register file and reference memory.
module tb_la_spi_target;
`ifdef LA_SPI_TARGET_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_sck = 1'b0, spi_csn = 1'b1, spi_sd = 1'b0;
  logic       spi_sd_out, spi_sd_oe, wr_valid, rd_req, busy, frame_err;
  logic [6:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;

  int vectors = 0;
  int miscompares = 0;

  la_spi_target dut (
    .clk(clk), .reset(reset),
    .spi_sck_in(spi_sck), .spi_csn_in(spi_csn), .spi_sd_in(spi_sd),
    .spi_sd_out(spi_sd_out), .spi_sd_oe(spi_sd_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Bench-side register file fed by the DUT; ref_mem is the expected contents.
  logic [7:0] rf [128];
  logic [7:0] ref_mem [128];
  assign rd_data = rf[rd_addr];
  always @(posedge clk) if (wr_valid) rf[wr_addr] <= wr_data;

  logic [14:0] wr_q[$];
  int rd_cnt, err_cnt;
  always @(negedge clk) begin
    if (wr_valid) wr_q.push_back({wr_addr, wr_data});
    if (rd_req) rd_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic clear_mon();
    wr_q.delete();
    rd_cnt = 0;
    err_cnt = 0;
  endtask

  // Mode-0 host: data set while sck low, sampled on rise; 16 clk per sck period.
  task automatic spi_frame(input logic [31:0] mosi, input int n, input int rst_bit, input int gap,
                           output logic [31:0] miso, output logic [31:0] oe);
    miso = '0;
    oe = '0;
    @(negedge clk);
    spi_csn = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      spi_sd = mosi[n-1-i];
      if (i == rst_bit) begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
      end
      repeat (8) @(negedge clk);
      miso[n-1-i] = spi_sd_out;
      oe[n-1-i] = spi_sd_oe;
      spi_sck = 1'b1;
      repeat (8) @(negedge clk);
      spi_sck = 1'b0;
    end
    repeat (8) @(negedge clk);
    spi_csn = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({wr_valid, rd_req, spi_sd_out, spi_sd_oe, busy, frame_err, wr_addr, wr_data, rd_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got wv=%b rr=%b so=%b oe=%b busy=%b err=%b wa=%h wd=%h ra=%h want all 0",
               wr_valid, rd_req, spi_sd_out, spi_sd_oe, busy, frame_err, wr_addr, wr_data, rd_addr);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if ({busy, spi_sd_oe, frame_err} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_release got busy/oe/err=%b want 000", {busy, spi_sd_oe, frame_err});
    end
    $display("reset: done");
  endtask

  task automatic test_write();
    logic [31:0] miso, oe;
    clear_mon();
    spi_frame({16'h0, 1'b0, 7'h05, 8'hA5}, 16, -1, 6, miso, oe);
    ref_mem[7'h05] = 8'hA5;
    vectors++;
    if (wr_q.size() != 1 || wr_q[0] !== {7'h05, 8'hA5}) begin
      miscompares++;
      $display("FAIL write_strobe got n=%0d first=%h want n=1 %h", wr_q.size(),
               wr_q.size() > 0 ? wr_q[0] : 15'h0, {7'h05, 8'hA5});
    end
    vectors++;
    if (err_cnt != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL write_status got err=%0d busy=%b want 0 0", err_cnt, busy);
    end
    $display("write 05=A5: strobes=%0d", wr_q.size());
  endtask

  task automatic test_read();
    logic [31:0] miso, oe;
    clear_mon();
    ref_mem[7'h12] = 8'h3C;
    rf[7'h12] = 8'h3C;
    spi_frame({16'h0, 1'b1, 7'h12, 8'h00}, 16, -1, 6, miso, oe);
    vectors++;
    if (miso[7:0] !== 8'h3C) begin
      miscompares++;
      $display("FAIL read_miso got %h want 3c", miso[7:0]);
    end
    vectors++;
    if (oe[15:0] !== 16'h00FF || spi_sd_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL read_oe got %h/%b want 00ff/0", oe[15:0], spi_sd_oe);
    end
    vectors++;
    if (rd_cnt != (BURST ? 2 : 1) || wr_q.size() != 0 || rd_addr !== (BURST ? 7'h13 : 7'h12)) begin
      miscompares++;
      $display("FAIL read_req got rd=%0d wr=%0d addr=%h want rd=%0d wr=0", rd_cnt, wr_q.size(), rd_addr,
               BURST ? 2 : 1);
    end
    $display("read 12: miso=%h", miso[7:0]);
  endtask

  task automatic test_frame_err();
    logic [31:0] miso, oe;
    clear_mon();
    spi_frame(32'h15, 5, -1, 6, miso, oe);
    vectors++;
    if (err_cnt != 1 || wr_q.size() != 0 || rd_cnt != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL err_cmd got err=%0d wr=%0d rd=%0d busy=%b want 1 0 0 0", err_cnt, wr_q.size(), rd_cnt, busy);
    end
    clear_mon();
    spi_frame({21'h0, 1'b0, 7'h33, 3'b101}, 11, -1, 6, miso, oe);
    vectors++;
    if (err_cnt != 1 || wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL err_data got err=%0d wr=%0d want 1 0", err_cnt, wr_q.size());
    end
    $display("frame_err: partial cmd and partial data");
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] miso, oe;
    clear_mon();
    spi_frame({16'h0, 1'b0, 7'h2A, 8'h5C}, 16, 11, 6, miso, oe);
    vectors++;
    if (wr_q.size() != 0 || err_cnt != 0) begin
      miscompares++;
      $display("FAIL reset_mid got wr=%0d err=%0d want 0 0", wr_q.size(), err_cnt);
    end
    clear_mon();
    spi_frame({16'h0, 1'b0, 7'h7F, 8'h01}, 16, -1, 6, miso, oe);
    ref_mem[7'h7F] = 8'h01;
    vectors++;
    if (wr_q.size() != 1 || wr_q[0] !== {7'h7F, 8'h01}) begin
      miscompares++;
      $display("FAIL reset_recover got n=%0d first=%h want n=1 %h", wr_q.size(),
               wr_q.size() > 0 ? wr_q[0] : 15'h0, {7'h7F, 8'h01});
    end
    $display("reset mid frame: recovered");
  endtask

  task automatic test_back_to_back();
    logic [31:0] miso, oe;
    clear_mon();
    spi_frame({16'h0, 1'b0, 7'h01, 8'hFF}, 16, -1, 1, miso, oe);
    ref_mem[7'h01] = 8'hFF;
    spi_frame({16'h0, 1'b1, 7'h01, 8'h00}, 16, -1, 6, miso, oe);
    vectors++;
    if (wr_q.size() != 1 || wr_q[0] !== {7'h01, 8'hFF}) begin
      miscompares++;
      $display("FAIL b2b_write got n=%0d want n=1 %h", wr_q.size(), {7'h01, 8'hFF});
    end
    vectors++;
    if (miso[7:0] !== 8'hFF || err_cnt != 0) begin
      miscompares++;
      $display("FAIL b2b_read got miso=%h err=%0d want ff 0", miso[7:0], err_cnt);
    end
    $display("back to back: miso=%h", miso[7:0]);
  endtask

  task automatic test_random();
    logic [31:0] miso, oe;
    logic [6:0] a;
    logic [7:0] d;
    bit rw;
    for (int k = 0; k < 24; k++) begin
      a = 7'($urandom_range(0, 127));
      d = 8'($urandom);
      rw = 1'($urandom);
      clear_mon();
      spi_frame({16'h0, rw, a, rw ? 8'h00 : d}, 16, -1, 3, miso, oe);
      vectors++;
      if (rw) begin
        if (miso[7:0] !== ref_mem[a] || rd_cnt != (BURST ? 2 : 1) || wr_q.size() != 0 || err_cnt != 0) begin
          miscompares++;
          $display("FAIL rand_read a=%h got miso=%h rd=%0d wr=%0d err=%0d want %h", a, miso[7:0], rd_cnt,
                   wr_q.size(), err_cnt, ref_mem[a]);
        end
        $display("rand read %h -> %h", a, miso[7:0]);
      end else begin
        ref_mem[a] = d;
        if (wr_q.size() != 1 || wr_q[0] !== {a, d} || rd_cnt != 0 || err_cnt != 0) begin
          miscompares++;
          $display("FAIL rand_write got n=%0d first=%h want n=1 %h", wr_q.size(),
                   wr_q.size() > 0 ? wr_q[0] : 15'h0, {a, d});
        end
        $display("rand write %h = %h", a, d);
      end
    end
  endtask

  task automatic test_burst();
    logic [31:0] miso, oe;
    logic [15:0] exp_rd;
    clear_mon();
    spi_frame({8'h0, 1'b0, 7'h7F, 8'h11, 8'h22}, 24, -1, 6, miso, oe);
    ref_mem[7'h7F] = 8'h11;
    if (BURST) ref_mem[7'h00] = 8'h22;
    vectors++;
    if (BURST ? (wr_q.size() != 2 || wr_q[0] !== {7'h7F, 8'h11} || wr_q[1] !== {7'h00, 8'h22})
              : (wr_q.size() != 1 || wr_q[0] !== {7'h7F, 8'h11})) begin
      miscompares++;
      $display("FAIL burst_write got n=%0d first=%h burst=%0d", wr_q.size(),
               wr_q.size() > 0 ? wr_q[0] : 15'h0, BURST);
    end
    clear_mon();
    spi_frame({8'h0, 1'b1, 7'h7F, 16'h0000}, 24, -1, 6, miso, oe);
    exp_rd = BURST ? {ref_mem[7'h7F], ref_mem[7'h00]} : {ref_mem[7'h7F], 8'h00};
    vectors++;
    if (miso[15:0] !== exp_rd || oe[23:0] !== (BURST ? 24'h00FFFF : 24'h00FF00)) begin
      miscompares++;
      $display("FAIL burst_read got miso=%h oe=%h want %h", miso[15:0], oe[23:0], exp_rd);
    end
    vectors++;
    if (rd_cnt != (BURST ? 3 : 1) || err_cnt != 0) begin
      miscompares++;
      $display("FAIL burst_rdreq got rd=%0d err=%0d want %0d 0", rd_cnt, err_cnt, BURST ? 3 : 1);
    end
    $display("burst=%0d: writes=%0d miso=%h", BURST, wr_q.size(), miso[15:0]);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = 8'($urandom);
      rf[i] = ref_mem[i];
    end
    clear_mon();
    test_reset();
    test_write();
    test_read();
    test_frame_err();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    test_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end
endmodule
